muldiv_ctrl: RTL and testbench

// - RV32M front end in the EX stage: decodes funct3, drives the external booth multiplier, runs division.
// - Booth handshake: mult held high, mult_resp pulse. Division runs on the div_radix2 sub-module.
// - Returns one 32-bit result with a single-cycle md_done pulse. Pipeline stalls while md_busy is high.

---
 rtl/muldiv_ctrl_pkg.sv | 30 +++
 rtl/muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_ctrl_div_radix2.sv | 62 ++++++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the RV32M multiply/divide front end: funct3 encoding,
// controller states and a small decode helper.
package muldiv_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_funct3_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } muldiv_state_t;

    function automatic logic is_div_op(input muldiv_funct3_t f);
        return f inside {DIV, DIVU, REM, REMU};
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side request/response bundle between the EX stage and muldiv_ctrl.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic                md_req;
    muldiv_funct3_t      md_funct3;
    logic [XLEN-1:0]     md_rs1;
    logic [XLEN-1:0]     md_rs2;
    logic                md_flush;
    logic                md_busy;
    logic                md_done;
    logic [XLEN-1:0]     md_result;

    modport master (
        output md_req, md_funct3, md_rs1, md_rs2, md_flush,
        input  md_busy, md_done, md_result
    );

    modport slave (
        input  md_req, md_funct3, md_rs1, md_rs2, md_flush,
        output md_busy, md_done, md_result
    );

endinterface

// File: rtl/muldiv_ctrl_div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle; div_done pulses
// exactly DIV_ITERS+1 cycles after the start pulse.
module div_radix2 #(
    parameter int DIV_ITERS = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem,
    output logic              div_done
);

    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] sub;
    logic              fits;

    // Partial remainder never exceeds the divisor, so the truncated difference is exact.
    assign shifted = {rem, quot[DATA_W-1]};
    assign fits    = shifted >= {1'b0, dvsr};
    assign sub     = shifted[DATA_W-1:0] - dvsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            dvsr     <= '0;
            quot     <= '0;
            rem      <= '0;
            div_done <= 1'b0;
        end else begin
            div_done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                quot <= dividend;
                rem  <= '0;
                dvsr <= divisor;
            end else if (busy) begin
                rem  <= fits ? sub : shifted[DATA_W-1:0];
                quot <= {quot[DATA_W-2:0], fits};
                cnt  <= cnt + 1'b1;
                if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                    busy     <= 1'b0;
                    div_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M front end: hands multiplies to the external booth unit, runs divides
// on div_radix2 and returns one result with a single-cycle md_done pulse.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    muldiv_ctrl_if.slave    md,
    output logic            mult,
    output logic            licand_sign,
    output logic            lier_sign,
    output logic [XLEN-1:0] licand,
    output logic [XLEN-1:0] lier,
    input  logic            mult_resp,
    input  logic [XLEN-1:0] product_l,
    input  logic [XLEN-1:0] product_u
);

    muldiv_state_t   state, state_nxt;
    muldiv_funct3_t  funct3_q;
    logic            div_first;
    logic [XLEN-1:0] result_q;

    logic            accept, op_signed, is_rem, special, neg_a, neg_b;
    logic            div_start, div_abort, div_done;
    logic [XLEN-1:0] mag_a, mag_b, quot, rem, special_res, div_res;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign accept    = (state == ST_IDLE) && md.md_req && !md.md_flush;
    assign op_signed = funct3_q inside {DIV, REM};
    assign is_rem    = funct3_q inside {REM, REMU};
    assign neg_a     = op_signed && licand[XLEN-1];
    assign neg_b     = op_signed && lier[XLEN-1];
    assign mag_a     = neg_if(licand, neg_a);
    assign mag_b     = neg_if(lier, neg_b);

    // Divide-by-zero and signed overflow bypass the divider entirely.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (lier == '0) begin
            special     = 1'b1;
            special_res = is_rem ? licand : '1;
        end else if (op_signed && licand == 32'h8000_0000 && lier == '1) begin
            special     = 1'b1;
            special_res = is_rem ? '0 : 32'h8000_0000;
        end
    end

    assign div_res = is_rem ? neg_if(rem, neg_a) : neg_if(quot, neg_a ^ neg_b);

    div_radix2 #(
        .DIV_ITERS (DIV_ITERS),
        .DATA_W    (XLEN)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quot     (quot),
        .rem      (rem),
        .div_done (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = is_div_op(md.md_funct3) ? ST_DIV : ST_MUL;
            ST_MUL: begin
                if (mult_resp)        state_nxt = md.md_flush ? ST_IDLE : ST_DONE;
                else if (md.md_flush) state_nxt = ST_DRAIN;
            end
            // Booth cannot be aborted, so a squashed multiply waits out its response.
            ST_DRAIN: if (mult_resp) state_nxt = ST_IDLE;
            ST_DIV: begin
                if (md.md_flush)                state_nxt = ST_IDLE;
                else if (div_first && special)  state_nxt = ST_DONE;
                else if (div_done)              state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        md.md_busy   = (state != ST_IDLE);
        md.md_done   = (state == ST_DONE) && !md.md_flush;
        md.md_result = md.md_done ? result_q : '0;
        mult         = (state == ST_MUL) || (state == ST_DRAIN);
        div_start    = (state == ST_DIV) && div_first && !special && !md.md_flush;
        div_abort    = (state == ST_DIV) && md.md_flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q    <= MUL;
            licand      <= '0;
            lier        <= '0;
            licand_sign <= 1'b0;
            lier_sign   <= 1'b0;
            div_first   <= 1'b0;
            result_q    <= '0;
        end else begin
            div_first <= accept && is_div_op(md.md_funct3);
            if (accept) begin
                funct3_q    <= md.md_funct3;
                licand      <= md.md_rs1;
                lier        <= md.md_rs2;
                licand_sign <= md.md_funct3 inside {MUL, MULH, MULHSU};
                lier_sign   <= md.md_funct3 inside {MUL, MULH};
            end
            if (state == ST_MUL && mult_resp && !md.md_flush) begin
                result_q <= (funct3_q == MUL) ? product_l : product_u;
            end else if (state == ST_DIV && !md.md_flush) begin
                if (div_first && special) result_q <= special_res;
                else if (div_done)        result_q <= div_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural booth multiplier model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int BOOTH_LAT = 35;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mult, licand_sign, lier_sign, mult_resp;
    logic [31:0] licand, lier, product_l, product_u;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          booth_cnt;
    logic        resp_prev = 1'b0;
    exp_t        sb_q[$];

    muldiv_ctrl_if mdif ();

    muldiv_ctrl #(.DIV_ITERS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .md          (mdif.slave),
        .mult        (mult),
        .licand_sign (licand_sign),
        .lier_sign   (lier_sign),
        .licand      (licand),
        .lier        (lier),
        .mult_resp   (mult_resp),
        .product_l   (product_l),
        .product_u   (product_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Booth model: mult_resp arrives in the BOOTH_LAT-th cycle that mult is high.
    always @(posedge clk or negedge rst_n) begin
        logic [63:0] ea, eb, p;
        if (!rst_n) begin
            booth_cnt <= 0;
            mult_resp <= 1'b0;
            product_l <= '0;
            product_u <= '0;
        end else if (mult_resp) begin
            mult_resp <= 1'b0;
            booth_cnt <= 0;
        end else if (mult) begin
            if (booth_cnt == BOOTH_LAT - 2) begin
                ea = {{32{licand_sign & licand[31]}}, licand};
                eb = {{32{lier_sign & lier[31]}}, lier};
                p  = ea * eb;
                mult_resp <= 1'b1;
                product_l <= p[31:0];
                product_u <= p[63:32];
                booth_cnt <= 0;
            end else begin
                booth_cnt <= booth_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mdif.md_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: md_result=%h, expected no md_done (cycle %0d)", mdif.md_result, cyc);
            end else begin
                e = sb_q.pop_front();
                chk({e.tag, "_result"}, mdif.md_result, e.res);
                chk({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
        if (resp_prev) chk("mult_drop_after_resp", {31'b0, mult}, 32'd0);
        resp_prev = mult_resp;
    end

    task automatic run_op(input string tag, input muldiv_funct3_t f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat);
        exp_t e;
        bit   seen;
        @(negedge clk);
        mdif.md_req    = 1'b1;
        mdif.md_funct3 = f;
        mdif.md_rs1    = a;
        mdif.md_rs2    = b;
        e.res = exp_res;
        e.due = cyc + lat;
        e.tag = tag;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < lat + 10 && !seen; i++) begin
            @(negedge clk);
            if (i == 0 && !is_div_op(f)) begin
                chk({tag, "_licand_sign"}, {31'b0, licand_sign}, {31'b0, f != MULHU});
                chk({tag, "_lier_sign"}, {31'b0, lier_sign}, {31'b0, (f == MUL) || (f == MULH)});
                chk({tag, "_mult_high"}, {31'b0, mult}, 32'd1);
            end
            if (mdif.md_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no md_done within %0d cycles", tag, lat + 10);
            sb_q.delete();
        end
        mdif.md_req = 1'b0;
    endtask

    initial begin
        int t0;
        rst_n          = 1'b0;
        mdif.md_req    = 1'b0;
        mdif.md_funct3 = MUL;
        mdif.md_rs1    = '0;
        mdif.md_rs2    = '0;
        mdif.md_flush  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, mdif.md_busy}, 32'd0);
        chk("rst_done", {31'b0, mdif.md_done}, 32'd0);
        chk("rst_result", mdif.md_result, 32'd0);
        chk("rst_mult", {31'b0, mult}, 32'd0);
        chk("rst_licand", licand, 32'd0);
        chk("rst_lier", lier, 32'd0);
        rst_n = 1'b1;

        run_op("mul_7x-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 36);
        run_op("mulh_min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 36);
        run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 36);
        run_op("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 36);
        run_op("div_-7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("rem_-7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("div_7_-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
        run_op("rem_7_-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 35);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 35);
        run_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("rem_5_0", REM, 32'd5, 32'd0, 32'd5, 2);
        run_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 2);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        // Squash a multiply at T+10: booth must still be drained to its response.
        @(negedge clk);
        mdif.md_req = 1'b1; mdif.md_funct3 = MUL; mdif.md_rs1 = 32'd5; mdif.md_rs2 = 32'd6;
        t0 = cyc;
        repeat (10) @(negedge clk);
        mdif.md_flush = 1'b1; mdif.md_req = 1'b0;
        @(negedge clk);
        mdif.md_flush = 1'b0;
        chk("drain_busy", {31'b0, mdif.md_busy}, 32'd1);
        chk("drain_mult", {31'b0, mult}, 32'd1);
        while (cyc < t0 + 35) @(negedge clk);
        chk("drain_resp", {31'b0, mult_resp}, 32'd1);
        chk("drain_mult_at_resp", {31'b0, mult}, 32'd1);
        @(negedge clk);
        chk("drain_idle", {31'b0, mdif.md_busy}, 32'd0);
        run_op("mul_3x4", MUL, 32'd3, 32'd4, 32'd12, 36);

        // Squash a divide: back to idle at once and no result.
        @(negedge clk);
        mdif.md_req = 1'b1; mdif.md_funct3 = DIVU; mdif.md_rs1 = 32'd100; mdif.md_rs2 = 32'd7;
        repeat (5) @(negedge clk);
        mdif.md_flush = 1'b1; mdif.md_req = 1'b0;
        @(negedge clk);
        mdif.md_flush = 1'b0;
        chk("div_flush_idle", {31'b0, mdif.md_busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        mdif.md_req = 1'b1; mdif.md_funct3 = DIVU; mdif.md_rs1 = 32'd100; mdif.md_rs2 = 32'd7;
        repeat (10) @(negedge clk);
        chk("mid_div_busy", {31'b0, mdif.md_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, mdif.md_busy}, 32'd0);
        chk("arst_done", {31'b0, mdif.md_done}, 32'd0);
        chk("arst_result", mdif.md_result, 32'd0);
        chk("arst_mult", {31'b0, mult}, 32'd0);
        chk("arst_licand", licand, 32'd0);
        @(negedge clk);
        mdif.md_req = 1'b0;
        rst_n = 1'b1;
        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 35);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
